// File: rtl/eth_loopback_responder_if.sv
// eth_loopback_responder_if: Ethernet header plus byte-stream payload bundle (eth_axis_rx/tx style)
interface eth_loopback_responder_if;
    logic        hdr_valid;
    logic        hdr_ready;
    logic [47:0] dest_mac;
    logic [47:0] src_mac;
    logic [15:0] eth_type;
    logic [7:0]  tdata;
    logic        tvalid;
    logic        tlast;
    logic        tuser;
    logic        tready;
    modport master (output hdr_valid, dest_mac, src_mac, eth_type, tdata, tvalid, tlast, tuser,
                    input hdr_ready, tready);
    modport slave (input hdr_valid, dest_mac, src_mac, eth_type, tdata, tvalid, tlast, tuser,
                   output hdr_ready, tready);
endinterface

// File: rtl/eth_loopback_responder.sv
// eth_loopback_responder: filters received frames, buffers one payload and echoes it back with swapped MACs
module eth_loopback_responder #(
    parameter int          BUF_DEPTH    = 2048,
    parameter logic [15:0] MATCH_TYPE_A = 16'h88B5,
    parameter logic [15:0] MATCH_TYPE_B = 16'h88B6,
    parameter logic [15:0] RESP_TYPE    = 16'h88B6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [47:0] local_mac,
    eth_loopback_responder_if.slave  s,
    eth_loopback_responder_if.master m,
    output logic [15:0] rx_good_count,
    output logic [15:0] rx_drop_count,
    output logic [15:0] tx_count
);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam logic [AW:0] DEPTH = (AW + 1)'(BUF_DEPTH);
    localparam logic [AW:0] ONE = (AW + 1)'(1);
    localparam logic [2:0] IDLE = 3'd0, RX = 3'd1, DROP = 3'd2, TX_HDR = 3'd3, TX = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [AW:0] cnt_q, cnt_d, len_q, len_d;
    logic [47:0] mac_q, mac_d;
    logic [15:0] good_q, good_d, drop_q, drop_d, txc_q, txc_d;
    logic        ram_v_q, ram_v_d, ram_last_q, ram_last_d;
    logic [7:0]  tdata_q, tdata_d;
    logic        tvalid_q, tvalid_d, tlast_q, tlast_d;
    logic [7:0]  mem [BUF_DEPTH];
    logic [7:0]  ram_q;
    logic        s_hdr_hs, pay_hs, m_hdr_hs, out_hs, accept, load, re, we;

    assign s.hdr_ready  = state_q == IDLE && !rst;
    assign s.tready     = state_q == RX || state_q == DROP;
    assign m.hdr_valid  = state_q == TX_HDR;
    assign m.dest_mac   = mac_q;
    assign m.src_mac    = local_mac;
    assign m.eth_type   = RESP_TYPE;
    assign m.tdata      = tdata_q;
    assign m.tvalid     = tvalid_q;
    assign m.tlast      = tlast_q;
    assign m.tuser      = 1'b0;
    assign rx_good_count = good_q;
    assign rx_drop_count = drop_q;
    assign tx_count      = txc_q;

    assign s_hdr_hs = s.hdr_valid && s.hdr_ready;
    assign pay_hs   = s.tvalid && s.tready;
    assign m_hdr_hs = m.hdr_valid && m.hdr_ready;
    assign out_hs   = tvalid_q && m.tready;
    assign accept   = (s.dest_mac == local_mac || s.dest_mac == '1) &&
                      (s.eth_type == MATCH_TYPE_A || s.eth_type == MATCH_TYPE_B);
    // Two-stage read pipeline: BRAM output register, then the output register that faces the sink.
    assign load = ram_v_q && (!tvalid_q || m.tready) && (state_q == TX || m_hdr_hs);
    assign re   = (state_q == TX_HDR || state_q == TX) && cnt_q < len_q && (!ram_v_q || load);
    assign we   = state_q == RX && pay_hs && cnt_q != DEPTH;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        mac_d      = mac_q;
        good_d     = good_q;
        drop_d     = drop_q;
        txc_d      = txc_q;
        ram_v_d    = ram_v_q;
        ram_last_d = ram_last_q;
        tdata_d    = tdata_q;
        tvalid_d   = tvalid_q;
        tlast_d    = tlast_q;
        case (state_q)
            IDLE: if (s_hdr_hs) begin
                mac_d   = s.src_mac;
                cnt_d   = '0;
                state_d = accept ? RX : DROP;
            end
            RX: if (pay_hs) begin
                if (cnt_q == DEPTH) begin
                    state_d = s.tlast ? IDLE : DROP;
                    drop_d  = s.tlast ? drop_q + 16'd1 : drop_q;
                end else begin
                    cnt_d = cnt_q + ONE;
                    if (s.tlast && s.tuser) begin
                        drop_d  = drop_q + 16'd1;
                        state_d = IDLE;
                    end else if (s.tlast) begin
                        len_d   = cnt_q + ONE;
                        cnt_d   = '0;
                        good_d  = good_q + 16'd1;
                        state_d = TX_HDR;
                    end
                end
            end
            DROP: if (pay_hs && s.tlast) begin
                drop_d  = drop_q + 16'd1;
                state_d = IDLE;
            end
            TX_HDR: if (m_hdr_hs) state_d = TX;
            TX: if (out_hs && tlast_q) begin
                txc_d   = txc_q + 16'd1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (re) begin
            cnt_d      = cnt_q + ONE;
            ram_v_d    = 1'b1;
            ram_last_d = cnt_q == len_q - ONE;
        end else if (load) begin
            ram_v_d = 1'b0;
        end
        if (load) begin
            tdata_d  = ram_q;
            tvalid_d = 1'b1;
            tlast_d  = ram_last_q;
        end else if (out_hs) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[cnt_q[AW-1:0]] <= s.tdata;
        if (re) ram_q <= mem[cnt_q[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            mac_q      <= '0;
            good_q     <= '0;
            drop_q     <= '0;
            txc_q      <= '0;
            ram_v_q    <= 1'b0;
            ram_last_q <= 1'b0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            mac_q      <= mac_d;
            good_q     <= good_d;
            drop_q     <= drop_d;
            txc_q      <= txc_d;
            ram_v_q    <= ram_v_d;
            ram_last_q <= ram_last_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
        end
    end
endmodule

// File: tb/tb_eth_loopback_responder.sv
// tb_eth_loopback_responder: directed frames against the echo responder, checked with immediate assertions
module tb_eth_loopback_responder;
    localparam int BD = 128;
    localparam logic [47:0] LMAC = 48'h02_00_00_00_00_01;
    localparam logic [47:0] SMAC = 48'h02_AA_BB_CC_DD_EE;
    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [47:0] local_mac = LMAC;
    logic [15:0] good, drop, txc;
    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  pay [0:BD];

    eth_loopback_responder_if s_if ();
    eth_loopback_responder_if m_if ();

    eth_loopback_responder #(.BUF_DEPTH(BD)) dut (
        .clk(clk), .rst(rst), .local_mac(local_mac), .s(s_if), .m(m_if),
        .rx_good_count(good), .rx_drop_count(drop), .tx_count(txc)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, observed running expected done");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input int n, input int base, input int step);
        for (int i = 0; i < n; i++) pay[i] = 8'(base + i * step);
    endtask

    task automatic send_hdr(input logic [47:0] dest, input logic [47:0] src, input logic [15:0] typ);
        int t = 0;
        s_if.hdr_valid = 1'b1;
        s_if.dest_mac = dest;
        s_if.src_mac = src;
        s_if.eth_type = typ;
        while (!s_if.hdr_ready && t < 100) begin tick; t++; end
        chk("hdr_accept", s_if.hdr_ready, 1'b1);
        tick;
        s_if.hdr_valid = 1'b0;
    endtask

    task automatic send_bytes(input int n, input int upto, input bit bad);
        for (int i = 0; i < upto; i++) begin
            int t = 0;
            s_if.tvalid = 1'b1;
            s_if.tdata = pay[i];
            s_if.tlast = i == n - 1;
            s_if.tuser = bad && i == n - 1;
            while (!s_if.tready && t < 100) begin tick; t++; end
            chk("pay_ready", s_if.tready, 1'b1);
            tick;
        end
        s_if.tvalid = 1'b0;
        s_if.tlast = 1'b0;
        s_if.tuser = 1'b0;
    endtask

    task automatic recv(input logic [47:0] dest_exp, input int n, input bit stall, input bit rnd,
                        input bit nogap, input int upto);
        int t = 0;
        int idx = 0;
        int first_wait = 0;
        bit held = 0;
        logic [7:0] hdata = '0;
        logic hlast = 1'b0;
        while (!m_if.hdr_valid && t < 50) begin tick; t++; end
        chk("resp_hdr_valid_rise", t, 0);
        chk("resp_dest", m_if.dest_mac, dest_exp);
        chk("resp_src", m_if.src_mac, LMAC);
        chk("resp_type", m_if.eth_type, 16'h88B6);
        if (stall) begin
            for (int k = 0; k < 20; k++) begin
                tick;
                chk("hdr_stall_valid", m_if.hdr_valid, 1'b1);
                chk("hdr_stall_dest", m_if.dest_mac, dest_exp);
                chk("hdr_stall_src", m_if.src_mac, LMAC);
                chk("hdr_stall_up_ready", s_if.hdr_ready, 1'b0);
                chk("hdr_stall_up_tready", s_if.tready, 1'b0);
                chk("hdr_stall_tvalid", m_if.tvalid, 1'b0);
            end
        end
        m_if.hdr_ready = 1'b1;
        tick;
        m_if.hdr_ready = 1'b0;
        t = 0;
        while (idx < upto && t < 20000) begin
            m_if.tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            chk("up_hdr_ready_low", s_if.hdr_ready, 1'b0);
            chk("up_tready_low", s_if.tready, 1'b0);
            if (held) begin
                chk("hold_valid", m_if.tvalid, 1'b1);
                chk("hold_data", m_if.tdata, hdata);
                chk("hold_last", m_if.tlast, hlast);
            end
            if (nogap && idx > 0) chk("no_gap", m_if.tvalid, 1'b1);
            if (idx == 0 && !m_if.tvalid) first_wait++;
            if (m_if.tvalid && m_if.tready) begin
                chk("tx_data", m_if.tdata, pay[idx]);
                chk("tx_last", m_if.tlast, idx == n - 1);
                chk("tx_user", m_if.tuser, 1'b0);
                idx++;
                held = 0;
            end else if (m_if.tvalid) begin
                held = 1;
                hdata = m_if.tdata;
                hlast = m_if.tlast;
            end
            tick;
            t++;
        end
        m_if.tready = 1'b0;
        chk("tx_byte_count", idx, upto);
        chk("first_byte_latency", first_wait <= 1, 1'b1);
        if (upto == n) begin
            chk("up_ready_back", s_if.hdr_ready, 1'b1);
            chk("tx_valid_done", m_if.tvalid, 1'b0);
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        #0;
        chk("rst_hdr_ready", s_if.hdr_ready, 1'b0);
        tick;
        rst = 1'b0;
        #0;
        chk("rst_hdr_ready_after", s_if.hdr_ready, 1'b1);
        chk("rst_tready", s_if.tready, 1'b0);
        chk("rst_m_hdr_valid", m_if.hdr_valid, 1'b0);
        chk("rst_tvalid", m_if.tvalid, 1'b0);
        chk("rst_tlast", m_if.tlast, 1'b0);
        chk("rst_tuser", m_if.tuser, 1'b0);
        chk("rst_good", good, 16'd0);
        chk("rst_drop", drop, 16'd0);
        chk("rst_tx", txc, 16'd0);
    endtask

    task automatic expect_silence;
        for (int k = 0; k < 4; k++) begin
            chk("no_response", m_if.hdr_valid, 1'b0);
            tick;
        end
        chk("idle_after_drop", s_if.hdr_ready, 1'b1);
    endtask

    initial begin
        s_if.hdr_valid = 1'b0;
        s_if.dest_mac = '0;
        s_if.src_mac = '0;
        s_if.eth_type = '0;
        s_if.tdata = '0;
        s_if.tvalid = 1'b0;
        s_if.tlast = 1'b0;
        s_if.tuser = 1'b0;
        m_if.hdr_ready = 1'b0;
        m_if.tready = 1'b0;
        tick;
        do_reset;

        fill(64, 0, 1);
        send_hdr(LMAC, SMAC, 16'h88B5);
        send_bytes(64, 64, 0);
        chk("t1_good", good, 16'd1);
        recv(SMAC, 64, 0, 0, 1, 64);
        chk("t1_tx", txc, 16'd1);

        fill(10, 8'h20, 1);
        send_hdr(48'h02_00_00_00_00_99, SMAC, 16'h88B5);
        send_bytes(10, 10, 0);
        expect_silence;
        send_hdr(LMAC, SMAC, 16'h0800);
        send_bytes(10, 10, 0);
        expect_silence;
        send_hdr(LMAC, SMAC, 16'h88B6);
        send_bytes(10, 10, 1);
        expect_silence;
        chk("t2_drop", drop, 16'd3);
        chk("t2_good", good, 16'd1);
        chk("t2_tx", txc, 16'd1);

        do_reset;
        fill(BD + 1, 8'h40, 1);
        send_hdr(LMAC, SMAC, 16'h88B5);
        send_bytes(BD + 1, BD + 1, 0);
        expect_silence;
        chk("t3_ovf_drop", drop, 16'd1);
        chk("t3_ovf_good", good, 16'd0);
        fill(10, 8'hA0, 5);
        send_hdr(LMAC, SMAC, 16'h88B5);
        send_bytes(10, 10, 0);
        recv(SMAC, 10, 0, 0, 1, 10);
        fill(BD, 3, 7);
        send_hdr(LMAC, SMAC, 16'h88B6);
        send_bytes(BD, BD, 0);
        recv(SMAC, BD, 0, 0, 1, BD);
        fill(1, 8'h5A, 0);
        send_hdr(LMAC, SMAC, 16'h88B5);
        send_bytes(1, 1, 0);
        recv(SMAC, 1, 0, 0, 1, 1);
        chk("t3_good", good, 16'd3);
        chk("t3_tx", txc, 16'd3);
        chk("t3_drop", drop, 16'd1);

        fill(40, 8'h11, 3);
        send_hdr(LMAC, 48'h02_12_34_56_78_9A, 16'h88B6);
        send_bytes(40, 40, 0);
        recv(48'h02_12_34_56_78_9A, 40, 1, 1, 0, 40);
        chk("t4_tx", txc, 16'd4);

        do_reset;
        for (int k = 0; k < 300; k++) begin
            int n = 1 + (k * 13) % 50;
            fill(n, k, 3);
            send_hdr(BCAST, SMAC ^ 48'(k), 16'h88B5);
            send_bytes(n, n, 0);
            recv(SMAC ^ 48'(k), n, 0, 0, 1, n);
        end
        chk("t5_good", good, 16'd300);
        chk("t5_tx", txc, 16'd300);
        chk("t5_drop", drop, 16'd0);

        fill(50, 8'h77, 1);
        send_hdr(LMAC, SMAC, 16'h88B5);
        send_bytes(50, 30, 0);
        do_reset;
        fill(12, 8'hC0, 9);
        send_hdr(LMAC, SMAC, 16'h88B5);
        send_bytes(12, 12, 0);
        recv(SMAC, 12, 0, 0, 1, 12);
        chk("t6_rx_rst_good", good, 16'd1);
        chk("t6_rx_rst_tx", txc, 16'd1);

        fill(20, 8'h31, 2);
        send_hdr(LMAC, SMAC, 16'h88B5);
        send_bytes(20, 20, 0);
        recv(SMAC, 20, 0, 0, 1, 5);
        do_reset;
        fill(7, 8'hE0, 1);
        send_hdr(BCAST, SMAC, 16'h88B6);
        send_bytes(7, 7, 0);
        recv(SMAC, 7, 0, 0, 1, 7);
        chk("t6_tx_rst_good", good, 16'd1);
        chk("t6_tx_rst_tx", txc, 16'd1);
        chk("t6_tx_rst_drop", drop, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
